// File: rtl/axi_s6_rr_arbiter.sv
// Four-master round-robin arbiter in front of NOC slave 6, with independent write and read paths.
// Optional address-window check with local error responses: define S6_ADDR_CHECK_EN.
module axi_s6_rr_arbiter #(
    parameter logic [31:0] S6_BASE   = 32'h0000_C000,
    parameter logic [31:0] S6_SIZE   = 32'h0000_1000,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    // master AW
    input  logic [3:0]                   m_awvalid_i,
    output logic [3:0]                   m_awready_o,
    input  logic [3:0][3:0]              m_awid_i,
    input  logic [3:0][31:0]             m_awaddr_i,
    input  logic [3:0][7:0]              m_awlen_i,
    input  logic [3:0][2:0]              m_awsize_i,
    input  logic [3:0][1:0]              m_awburst_i,
    // master W
    input  logic [3:0]                   m_wvalid_i,
    input  logic [3:0]                   m_wlast_i,
    output logic [3:0]                   m_wready_o,
    input  logic [3:0][DATA_W-1:0]       m_wdata_i,
    input  logic [3:0][DATA_W/8-1:0]     m_wstrb_i,
    // master B
    output logic [3:0]                   m_bvalid_o,
    input  logic [3:0]                   m_bready_i,
    output logic [3:0]                   m_bid_o,
    output logic [1:0]                   m_bresp_o,
    // master AR
    input  logic [3:0]                   m_arvalid_i,
    output logic [3:0]                   m_arready_o,
    input  logic [3:0][3:0]              m_arid_i,
    input  logic [3:0][31:0]             m_araddr_i,
    input  logic [3:0][7:0]              m_arlen_i,
    input  logic [3:0][2:0]              m_arsize_i,
    input  logic [3:0][1:0]              m_arburst_i,
    // master R
    output logic [3:0]                   m_rvalid_o,
    input  logic [3:0]                   m_rready_i,
    output logic [3:0]                   m_rid_o,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic [1:0]                   m_rresp_o,
    output logic                         m_rlast_o,
    // slave 6 AW
    output logic                         s6_awvalid_o,
    input  logic                         s6_awready_i,
    output logic [5:0]                   s6_awid_o,
    output logic [31:0]                  s6_awaddr_o,
    output logic [7:0]                   s6_awlen_o,
    output logic [2:0]                   s6_awsize_o,
    output logic [1:0]                   s6_awburst_o,
    // slave 6 W
    output logic                         s6_wvalid_o,
    input  logic                         s6_wready_i,
    output logic [DATA_W-1:0]            s6_wdata_o,
    output logic [DATA_W/8-1:0]          s6_wstrb_o,
    output logic                         s6_wlast_o,
    // slave 6 B
    input  logic                         s6_bvalid_i,
    output logic                         s6_bready_o,
    input  logic [5:0]                   s6_bid_i,
    input  logic [1:0]                   s6_bresp_i,
    // slave 6 AR
    output logic                         s6_arvalid_o,
    input  logic                         s6_arready_i,
    output logic [5:0]                   s6_arid_o,
    output logic [31:0]                  s6_araddr_o,
    output logic [7:0]                   s6_arlen_o,
    output logic [2:0]                   s6_arsize_o,
    output logic [1:0]                   s6_arburst_o,
    // slave 6 R
    input  logic                         s6_rvalid_i,
    output logic                         s6_rready_o,
    input  logic [5:0]                   s6_rid_i,
    input  logic [DATA_W-1:0]            s6_rdata_i,
    input  logic [1:0]                   s6_rresp_i,
    input  logic                         s6_rlast_i
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [31:0] S6_LAST = S6_BASE + S6_SIZE - 32'd1;
`ifdef S6_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_EDRAIN, W_ERESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_ERR} rd_state_e;

    wr_state_e          wr_st_q;
    rd_state_e          rd_st_q;
    logic [1:0]         wg_q, rg_q;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [3:0]         werr_id_q, rerr_id_q;
    logic [7:0]         rerr_left_q;

    logic [1:0]         wpick, rpick, bsel, rsel;
    logic               aw_ok, ar_ok, aw_hs, ar_hs, b_hs, rl_hs;

    // First requester strictly after the last grant, wrapping around
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign wpick = rr_pick(m_awvalid_i, wg_q);
    assign rpick = rr_pick(m_arvalid_i, rg_q);
    assign aw_ok = !ADDR_CHK || ((m_awaddr_i[wg_q] >= S6_BASE) && (m_awaddr_i[wg_q] <= S6_LAST));
    assign ar_ok = !ADDR_CHK || ((m_araddr_i[rg_q] >= S6_BASE) && (m_araddr_i[rg_q] <= S6_LAST));
    assign bsel  = s6_bid_i[5:4];
    assign rsel  = s6_rid_i[5:4];

    assign aw_hs = s6_awvalid_o && s6_awready_i;
    assign ar_hs = s6_arvalid_o && s6_arready_i;
    assign b_hs  = s6_bvalid_i && s6_bready_o;
    assign rl_hs = s6_rvalid_i && s6_rready_o && s6_rlast_i;

    // Outstanding counters: a simultaneous issue and retire cancel out
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (aw_hs && !b_hs)      wr_cnt_d = wr_cnt_q + CNT_W'(1);
        else if (!aw_hs && b_hs) wr_cnt_d = wr_cnt_q - CNT_W'(1);
        if (ar_hs && !rl_hs)      rd_cnt_d = rd_cnt_q + CNT_W'(1);
        else if (!ar_hs && rl_hs) rd_cnt_d = rd_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_st_q     <= W_IDLE;
            rd_st_q     <= R_IDLE;
            wg_q        <= 2'd3;
            rg_q        <= 2'd3;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            werr_id_q   <= '0;
            rerr_id_q   <= '0;
            rerr_left_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;

            case (wr_st_q)
                W_IDLE: begin
                    if ((|m_awvalid_i) && (wr_cnt_q < CNT_W'(MAX_OUTST))) begin
                        wg_q    <= wpick;
                        wr_st_q <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (!aw_ok) begin
                        werr_id_q <= m_awid_i[wg_q];
                        wr_st_q   <= W_EDRAIN;
                    end else if (s6_awready_i) begin
                        wr_st_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (m_wvalid_i[wg_q] && s6_wready_i && m_wlast_i[wg_q]) wr_st_q <= W_IDLE;
                end
                W_EDRAIN: begin
                    if (m_wvalid_i[wg_q] && m_wlast_i[wg_q]) wr_st_q <= W_ERESP;
                end
                W_ERESP: begin
                    if (m_bready_i[wg_q]) wr_st_q <= W_IDLE;
                end
                default: wr_st_q <= W_IDLE;
            endcase

            case (rd_st_q)
                R_IDLE: begin
                    if ((|m_arvalid_i) && (rd_cnt_q < CNT_W'(MAX_OUTST))) begin
                        rg_q    <= rpick;
                        rd_st_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (!ar_ok) begin
                        rerr_id_q   <= m_arid_i[rg_q];
                        rerr_left_q <= m_arlen_i[rg_q];
                        rd_st_q     <= R_ERR;
                    end else if (s6_arready_i) begin
                        rd_st_q <= R_IDLE;
                    end
                end
                R_ERR: begin
                    if (m_rready_i[rg_q]) begin
                        if (rerr_left_q == 8'd0) rd_st_q <= R_IDLE;
                        else                     rerr_left_q <= rerr_left_q - 8'd1;
                    end
                end
                default: rd_st_q <= R_IDLE;
            endcase
        end
    end

    // Write path muxing and B routing; a local error response owns the B bus
    always_comb begin
        m_awready_o  = '0;
        m_wready_o   = '0;
        s6_awvalid_o = 1'b0;
        s6_awid_o    = {wg_q, m_awid_i[wg_q]};
        s6_awaddr_o  = m_awaddr_i[wg_q];
        s6_awlen_o   = m_awlen_i[wg_q];
        s6_awsize_o  = m_awsize_i[wg_q];
        s6_awburst_o = m_awburst_i[wg_q];
        s6_wvalid_o  = 1'b0;
        s6_wdata_o   = m_wdata_i[wg_q];
        s6_wstrb_o   = m_wstrb_i[wg_q];
        s6_wlast_o   = m_wlast_i[wg_q];
        case (wr_st_q)
            W_ADDR: begin
                s6_awvalid_o      = aw_ok;
                m_awready_o[wg_q] = aw_ok ? s6_awready_i : 1'b1;
            end
            W_DATA: begin
                s6_wvalid_o      = m_wvalid_i[wg_q];
                m_wready_o[wg_q] = s6_wready_i;
            end
            W_EDRAIN: m_wready_o[wg_q] = 1'b1;
            default: ;
        endcase

        m_bvalid_o       = '0;
        m_bvalid_o[bsel] = s6_bvalid_i;
        s6_bready_o      = m_bready_i[bsel];
        m_bid_o          = s6_bid_i[3:0];
        m_bresp_o        = s6_bresp_i;
        if (wr_st_q == W_ERESP) begin
            m_bvalid_o       = '0;
            m_bvalid_o[wg_q] = 1'b1;
            s6_bready_o      = 1'b0;
            m_bid_o          = werr_id_q;
            m_bresp_o        = 2'b11;
        end
    end

    // Read path muxing and R routing; a local error burst owns the R bus
    always_comb begin
        m_arready_o  = '0;
        s6_arvalid_o = 1'b0;
        s6_arid_o    = {rg_q, m_arid_i[rg_q]};
        s6_araddr_o  = m_araddr_i[rg_q];
        s6_arlen_o   = m_arlen_i[rg_q];
        s6_arsize_o  = m_arsize_i[rg_q];
        s6_arburst_o = m_arburst_i[rg_q];
        if (rd_st_q == R_ADDR) begin
            s6_arvalid_o      = ar_ok;
            m_arready_o[rg_q] = ar_ok ? s6_arready_i : 1'b1;
        end

        m_rvalid_o       = '0;
        m_rvalid_o[rsel] = s6_rvalid_i;
        s6_rready_o      = m_rready_i[rsel];
        m_rid_o          = s6_rid_i[3:0];
        m_rdata_o        = s6_rdata_i;
        m_rresp_o        = s6_rresp_i;
        m_rlast_o        = s6_rlast_i;
        if (rd_st_q == R_ERR) begin
            m_rvalid_o       = '0;
            m_rvalid_o[rg_q] = 1'b1;
            s6_rready_o      = 1'b0;
            m_rid_o          = rerr_id_q;
            m_rdata_o        = '0;
            m_rresp_o        = 2'b11;
            m_rlast_o        = (rerr_left_q == 8'd0);
        end
    end

endmodule

// File: tb/tb_axi_s6_rr_arbiter.sv
// Self-checking bench for axi_s6_rr_arbiter: per-scenario tasks plus a scoreboard on slave-6 AW/AR/W.
// Define S6_ADDR_CHECK_EN for both RTL and bench to exercise local error responses.
module tb_axi_s6_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic [3:0][3:0]   m_awid, m_wstrb, m_arid;
    logic [3:0][31:0]  m_awaddr, m_wdata, m_araddr;
    logic [3:0][7:0]   m_awlen, m_arlen;
    logic [3:0][2:0]   m_awsize, m_arsize;
    logic [3:0][1:0]   m_awburst, m_arburst;
    logic [3:0]        m_bid, m_arvalid, m_arready, m_rvalid, m_rready, m_rid;
    logic [1:0]        m_bresp, m_rresp;
    logic [31:0]       m_rdata;
    logic              m_rlast;
    logic              s6_awvalid, s6_awready, s6_wvalid, s6_wready, s6_wlast;
    logic [5:0]        s6_awid, s6_bid, s6_arid, s6_rid;
    logic [31:0]       s6_awaddr, s6_wdata, s6_araddr, s6_rdata;
    logic [7:0]        s6_awlen, s6_arlen;
    logic [2:0]        s6_awsize, s6_arsize;
    logic [1:0]        s6_awburst, s6_arburst, s6_bresp, s6_rresp;
    logic [3:0]        s6_wstrb;
    logic              s6_bvalid, s6_bready, s6_arvalid, s6_arready, s6_rvalid, s6_rready, s6_rlast;

    axi_s6_rr_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .m_awvalid_i(m_awvalid), .m_awready_o(m_awready), .m_awid_i(m_awid), .m_awaddr_i(m_awaddr),
        .m_awlen_i(m_awlen), .m_awsize_i(m_awsize), .m_awburst_i(m_awburst),
        .m_wvalid_i(m_wvalid), .m_wlast_i(m_wlast), .m_wready_o(m_wready),
        .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_bvalid_o(m_bvalid), .m_bready_i(m_bready), .m_bid_o(m_bid), .m_bresp_o(m_bresp),
        .m_arvalid_i(m_arvalid), .m_arready_o(m_arready), .m_arid_i(m_arid), .m_araddr_i(m_araddr),
        .m_arlen_i(m_arlen), .m_arsize_i(m_arsize), .m_arburst_i(m_arburst),
        .m_rvalid_o(m_rvalid), .m_rready_i(m_rready), .m_rid_o(m_rid), .m_rdata_o(m_rdata),
        .m_rresp_o(m_rresp), .m_rlast_o(m_rlast),
        .s6_awvalid_o(s6_awvalid), .s6_awready_i(s6_awready), .s6_awid_o(s6_awid),
        .s6_awaddr_o(s6_awaddr), .s6_awlen_o(s6_awlen), .s6_awsize_o(s6_awsize), .s6_awburst_o(s6_awburst),
        .s6_wvalid_o(s6_wvalid), .s6_wready_i(s6_wready), .s6_wdata_o(s6_wdata),
        .s6_wstrb_o(s6_wstrb), .s6_wlast_o(s6_wlast),
        .s6_bvalid_i(s6_bvalid), .s6_bready_o(s6_bready), .s6_bid_i(s6_bid), .s6_bresp_i(s6_bresp),
        .s6_arvalid_o(s6_arvalid), .s6_arready_i(s6_arready), .s6_arid_o(s6_arid),
        .s6_araddr_o(s6_araddr), .s6_arlen_o(s6_arlen), .s6_arsize_o(s6_arsize), .s6_arburst_o(s6_arburst),
        .s6_rvalid_i(s6_rvalid), .s6_rready_o(s6_rready), .s6_rid_i(s6_rid), .s6_rdata_i(s6_rdata),
        .s6_rresp_i(s6_rresp), .s6_rlast_i(s6_rlast)
    );

    typedef struct packed { logic [5:0] id; logic [31:0] addr; } a_exp_t;
    typedef struct packed { logic [31:0] data; logic last; } w_exp_t;

    a_exp_t exp_aw[$];
    a_exp_t exp_ar[$];
    w_exp_t exp_w[$];
    a_exp_t aw_e, ar_e;
    w_exp_t w_e;
    int     checks = 0;
    int     errors = 0;
    int     aw_seen = 0, ar_seen = 0, w_seen = 0;
    bit     w_chk_en = 1'b0;

    // Scoreboard: every slave-6 address/data handshake must match the next expected entry
    always @(negedge clk) begin
        if (!rst && s6_awvalid && s6_awready) begin
            aw_seen++;
            checks++;
            if (exp_aw.size() == 0) begin
                errors++;
                $display("FAIL aw_unexpected: got id=%h addr=%h, required no AW", s6_awid, s6_awaddr);
            end else begin
                aw_e = exp_aw.pop_front();
                if ({s6_awid, s6_awaddr} !== {aw_e.id, aw_e.addr}) begin
                    errors++;
                    $display("FAIL aw_payload: got id=%h addr=%h, required id=%h addr=%h",
                             s6_awid, s6_awaddr, aw_e.id, aw_e.addr);
                end
            end
        end
        if (!rst && s6_arvalid && s6_arready) begin
            ar_seen++;
            checks++;
            if (exp_ar.size() == 0) begin
                errors++;
                $display("FAIL ar_unexpected: got id=%h addr=%h, required no AR", s6_arid, s6_araddr);
            end else begin
                ar_e = exp_ar.pop_front();
                if ({s6_arid, s6_araddr} !== {ar_e.id, ar_e.addr}) begin
                    errors++;
                    $display("FAIL ar_payload: got id=%h addr=%h, required id=%h addr=%h",
                             s6_arid, s6_araddr, ar_e.id, ar_e.addr);
                end
            end
        end
        if (!rst && w_chk_en && s6_wvalid && s6_wready) begin
            w_seen++;
            checks++;
            if (exp_w.size() == 0) begin
                errors++;
                $display("FAIL w_unexpected: got data=%h, required no W", s6_wdata);
            end else begin
                w_e = exp_w.pop_front();
                if ({s6_wdata, s6_wlast} !== {w_e.data, w_e.last}) begin
                    errors++;
                    $display("FAIL w_beat: got data=%h last=%b, required data=%h last=%b",
                             s6_wdata, s6_wlast, w_e.data, w_e.last);
                end
            end
        end
    end

    task automatic wait_seen(input int which, input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            #1;
            case (which)
                0:       ok = (aw_seen >= target);
                1:       ok = (ar_seen >= target);
                default: ok = (w_seen >= target);
            endcase
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wdata = '0; m_wstrb = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        s6_awready = 1'b0; s6_wready = 1'b0; s6_bvalid = 1'b0; s6_bid = '0; s6_bresp = '0;
        s6_arready = 1'b0; s6_rvalid = 1'b0; s6_rid = '0; s6_rdata = '0; s6_rresp = '0; s6_rlast = 1'b0;
        w_chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({s6_awvalid, s6_wvalid, s6_arvalid} !== 3'b000) begin
            errors++; $display("FAIL reset_s6_valid: got %b, required 000", {s6_awvalid, s6_wvalid, s6_arvalid});
        end
        checks++;
        if ({m_awready, m_wready, m_arready} !== 12'h000) begin
            errors++; $display("FAIL reset_m_ready: got %h, required 000", {m_awready, m_wready, m_arready});
        end
        checks++;
        if ({m_bvalid, m_rvalid} !== 8'h00) begin
            errors++; $display("FAIL reset_m_valid: got %h, required 00", {m_bvalid, m_rvalid});
        end
        checks++;
        if ({s6_bready, s6_rready} !== 2'b00) begin
            errors++; $display("FAIL reset_s6_ready: got %b, required 00", {s6_bready, s6_rready});
        end
    endtask

    // All four masters request; grants rotate 0..3, then the outstanding limit blocks the fifth
    task automatic test_rr_outstanding();
        bit ok;
        int base;
        apply_reset();
        base = aw_seen;
        for (int i = 0; i < 4; i++) begin
            m_awid[i]   = 4'(i);
            m_awaddr[i] = 32'h0000_C000 + 32'(i * 16);
            exp_aw.push_back('{id: {2'(i), 4'(i)}, addr: 32'h0000_C000 + 32'(i * 16)});
        end
        exp_aw.push_back('{id: 6'h00, addr: 32'h0000_C000});
        m_wvalid = 4'hF; m_wlast = 4'hF; s6_awready = 1'b1; s6_wready = 1'b1;
        m_awvalid = 4'hF;
        wait_seen(0, base + 4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_four_grants: got %0d AWs, required 4", aw_seen - base); end
        repeat (10) @(negedge clk);
        checks++;
        if ((aw_seen - base) !== 4 || s6_awvalid !== 1'b0) begin
            errors++; $display("FAIL outst_limit: got %0d AWs awvalid=%b, required 4 and 0", aw_seen - base, s6_awvalid);
        end
        @(posedge clk);
        #1;
        s6_bvalid = 1'b1; s6_bid = 6'h00; s6_bresp = 2'b00; m_bready = 4'b0001;
        @(negedge clk);
        checks++;
        if ({m_bvalid, m_bid, s6_bready} !== {4'b0001, 4'h0, 1'b1}) begin
            errors++; $display("FAIL b_route_m0: got bvalid=%b bid=%h bready=%b, required 0001 0 1", m_bvalid, m_bid, s6_bready);
        end
        @(posedge clk);
        #1;
        s6_bvalid = 1'b0; m_bready = '0;
        wait_seen(0, base + 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL grant_after_b: got %0d AWs, required 5", aw_seen - base); end
        @(posedge clk);
        #1;
        m_awvalid = '0;
        repeat (3) @(posedge clk);
    endtask

    // Single M2 burst: ID tagging, four data beats, B routed only to M2
    task automatic test_m2_write();
        bit ok;
        int beat;
        apply_reset();
        w_chk_en = 1'b1;
        m_awid[2] = 4'h5; m_awaddr[2] = 32'h0000_C010; m_awlen[2] = 8'd3; m_awsize[2] = 3'd2; m_awburst[2] = 2'b01;
        exp_aw.push_back('{id: 6'h25, addr: 32'h0000_C010});
        s6_awready = 1'b1; s6_wready = 1'b1;
        m_awvalid[2] = 1'b1;
        wait_seen(0, aw_seen + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL m2_aw: got no AW handshake, required one"); end
        @(posedge clk);
        #1;
        m_awvalid = '0;
        beat = 0;
        m_wvalid[2] = 1'b1; m_wstrb[2] = 4'hF; m_wdata[2] = 32'h1000_0000; m_wlast[2] = 1'b0;
        exp_w.push_back('{data: 32'h1000_0000, last: 1'b0});
        for (int c = 0; c < 50 && beat < 4; c++) begin
            @(negedge clk);
            if (m_wready[2]) begin
                beat++;
                @(posedge clk);
                #1;
                if (beat < 4) begin
                    m_wdata[2] = 32'h1000_0000 + 32'(beat);
                    m_wlast[2] = (beat == 3);
                    exp_w.push_back('{data: 32'h1000_0000 + 32'(beat), last: (beat == 3)});
                end else begin
                    m_wvalid = '0; m_wlast = '0;
                end
            end
        end
        checks++;
        if (beat !== 4) begin errors++; $display("FAIL m2_w_beats: got %0d beats, required 4", beat); end
        s6_bvalid = 1'b1; s6_bid = 6'h25; s6_bresp = 2'b00; m_bready = 4'b0001;
        @(negedge clk);
        checks++;
        if ({m_bvalid, s6_bready} !== {4'b0100, 1'b0}) begin
            errors++; $display("FAIL b_route_m2_wrong_ready: got bvalid=%b bready=%b, required 0100 0", m_bvalid, s6_bready);
        end
        @(posedge clk);
        #1;
        m_bready = 4'b0100;
        @(negedge clk);
        checks++;
        if ({m_bvalid, m_bid, s6_bready} !== {4'b0100, 4'h5, 1'b1}) begin
            errors++; $display("FAIL b_route_m2: got bvalid=%b bid=%h bready=%b, required 0100 5 1", m_bvalid, m_bid, s6_bready);
        end
        @(posedge clk);
        #1;
        s6_bvalid = 1'b0; m_bready = '0; w_chk_en = 1'b0;
    endtask

    // Read and write paths grant independently in the same cycle; R routed back by ID
    task automatic test_concurrent();
        bit ok;
        apply_reset();
        m_arid[1] = 4'hA; m_araddr[1] = 32'h0000_C100; m_arlen[1] = 8'd0;
        m_awid[3] = 4'h3; m_awaddr[3] = 32'h0000_C200;
        m_arvalid[1] = 1'b1; m_awvalid[3] = 1'b1;
        @(negedge clk);
        checks++;
        if ({s6_arvalid, s6_awvalid} !== 2'b00) begin
            errors++; $display("FAIL grant_latency: got ar/aw valid=%b, required 00", {s6_arvalid, s6_awvalid});
        end
        @(negedge clk);
        checks++;
        if ({s6_arvalid, s6_awvalid, s6_arid[5:4], s6_awid[5:4]} !== {2'b11, 2'd1, 2'd3}) begin
            errors++; $display("FAIL concurrent_grant: got valid=%b arsel=%0d awsel=%0d, required 11 1 3",
                               {s6_arvalid, s6_awvalid}, s6_arid[5:4], s6_awid[5:4]);
        end
        exp_ar.push_back('{id: 6'h1A, addr: 32'h0000_C100});
        @(posedge clk);
        #1;
        s6_arready = 1'b1;
        wait_seen(1, ar_seen + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL m1_ar: got no AR handshake, required one"); end
        @(posedge clk);
        #1;
        m_arvalid = '0; s6_arready = 1'b0;
        s6_rvalid = 1'b1; s6_rid = 6'h1A; s6_rdata = 32'hDEAD_BEEF; s6_rresp = 2'b00; s6_rlast = 1'b1;
        m_rready = 4'b0010;
        @(negedge clk);
        checks++;
        if ({m_rvalid, m_rid, m_rdata, m_rlast, s6_rready} !== {4'b0010, 4'hA, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
            errors++; $display("FAIL r_route_m1: got rvalid=%b rid=%h rdata=%h rlast=%b rready=%b, required 0010 a deadbeef 1 1",
                               m_rvalid, m_rid, m_rdata, m_rlast, s6_rready);
        end
        @(posedge clk);
        #1;
        s6_rvalid = 1'b0; m_rready = '0; s6_rlast = 1'b0;
    endtask

    // Reset in the middle of a write burst clears outputs and restarts arbitration at M0
    task automatic test_reset_mid_burst();
        bit ok;
        int acc;
        apply_reset();
        m_awid[1] = 4'h2; m_awaddr[1] = 32'h0000_C040; m_awlen[1] = 8'd3;
        exp_aw.push_back('{id: 6'h12, addr: 32'h0000_C040});
        s6_awready = 1'b1; s6_wready = 1'b1;
        m_awvalid[1] = 1'b1;
        wait_seen(0, aw_seen + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL m1_aw: got no AW handshake, required one"); end
        @(posedge clk);
        #1;
        m_awvalid = '0; m_wvalid[1] = 1'b1; m_wlast[1] = 1'b0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(negedge clk);
            if (m_wready[1]) acc++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({s6_awvalid, s6_wvalid, m_awready, m_wready} !== 10'h000) begin
            errors++; $display("FAIL mid_burst_reset: got %h, required 000", {s6_awvalid, s6_wvalid, m_awready, m_wready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0; m_wvalid = '0; s6_awready = 1'b0;
        m_awvalid = 4'b1101;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({s6_awvalid, s6_awid[5:4]} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL post_reset_grant: got valid=%b sel=%0d, required 1 0", s6_awvalid, s6_awid[5:4]);
        end
        @(posedge clk);
        #1;
        m_awvalid = '0;
    endtask

    // Read to 0xD000 (outside the slave-6 window), two beats
    task automatic test_addr_window();
        bit ok;
        bit saw_fwd, arr_seen;
        int beats;
        apply_reset();
        m_arid[0] = 4'h7; m_araddr[0] = 32'h0000_D000; m_arlen[0] = 8'd1;
        s6_arready = 1'b1; m_rready = 4'b0001;
`ifdef S6_ADDR_CHECK_EN
        m_arvalid[0] = 1'b1;
        saw_fwd = 1'b0; arr_seen = 1'b0; beats = 0;
        for (int c = 0; c < 40 && beats < 2; c++) begin
            @(negedge clk);
            if (s6_arvalid) saw_fwd = 1'b1;
            if (m_arready[0]) arr_seen = 1'b1;
            if (m_rvalid[0]) begin
                checks++;
                if ({m_rresp, m_rdata, m_rid, m_rlast} !== {2'b11, 32'h0, 4'h7, (beats == 1)}) begin
                    errors++; $display("FAIL err_r_beat%0d: got resp=%b data=%h id=%h last=%b, required 11 0 7 %b",
                                       beats, m_rresp, m_rdata, m_rid, m_rlast, (beats == 1));
                end
                beats++;
            end
            @(posedge clk);
            #1;
            if (arr_seen) m_arvalid = '0;
        end
        checks++;
        if ({saw_fwd, arr_seen} !== 2'b01 || beats !== 2) begin
            errors++; $display("FAIL err_read: got fwd=%b arready=%b beats=%0d, required 0 1 2", saw_fwd, arr_seen, beats);
        end
        @(negedge clk);
        checks++;
        if (m_rvalid !== 4'b0000) begin errors++; $display("FAIL err_read_end: got rvalid=%b, required 0000", m_rvalid); end
`else
        saw_fwd = 1'b0; arr_seen = 1'b0; beats = 0;
        exp_ar.push_back('{id: 6'h07, addr: 32'h0000_D000});
        m_arvalid[0] = 1'b1;
        wait_seen(1, ar_seen + 1, ok);
        checks++;
        if (!ok || saw_fwd || arr_seen || beats != 0) begin
            errors++; $display("FAIL addr_forward: got no AR for 0xD000, required forwarded");
        end
        @(posedge clk);
        #1;
        m_arvalid = '0;
`endif
        m_rready = '0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_rr_outstanding();
        test_m2_write();
        test_concurrent();
        test_reset_mid_burst();
        test_addr_window();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_aw.size() != 0 || exp_ar.size() != 0 || exp_w.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got aw=%0d ar=%0d w=%0d pending, required 0",
                               exp_aw.size(), exp_ar.size(), exp_w.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
